// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default line timing and the
// clocks-per-bit derivation used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_t;

  localparam int unsigned DEF_CLK_FREQ  = 125_000_000;
  localparam int unsigned DEF_BAUD_RATE = 230_400;

  function automatic int unsigned calc_bit_time(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned calc_half_bit(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return calc_bit_time(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; resets to 1 so an
// idle-high line reads as idle straight out of reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b1;
      q       <= 1'b1;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 framing
// with a parity_err pulse. Samples the synchronized line at mid-bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_rdy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned BIT_TIME  = calc_bit_time(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT  = calc_half_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_TIME - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif

  logic        rx_s;
  uart_state_t state, state_nxt;
  logic [15:0] clk_count, clk_count_nxt;
  logic [3:0]  bit_index, bit_index_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  data_nxt;
  logic        data_rdy_nxt, frame_err_nxt;
  logic        par_ok;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nxt, parity_err_nxt;
  assign par_ok = ~par_bad;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    clk_count_nxt = clk_count;
    bit_index_nxt = bit_index;
    shift_nxt     = shift;
    data_nxt      = data;
    data_rdy_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt    = par_bad;
    parity_err_nxt = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        clk_count_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (clk_count == HALF_LAST) begin
          // A start bit that is high again at its mid-point was only a glitch.
          clk_count_nxt = '0;
          bit_index_nxt = '0;
          state_nxt     = rx_s ? IDLE : DATA;
        end else begin
          clk_count_nxt = clk_count + 16'd1;
        end
      end
      DATA: begin
        if (clk_count == BIT_LAST) begin
          clk_count_nxt = '0;
          shift_nxt     = {rx_s, shift[7:1]};
          bit_index_nxt = bit_index + 4'd1;
          if (bit_index == 4'd7) state_nxt = AFTER_DATA;
        end else begin
          clk_count_nxt = clk_count + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_count == BIT_LAST) begin
          clk_count_nxt  = '0;
          par_bad_nxt    = ^{shift, rx_s};
          parity_err_nxt = ^{shift, rx_s};
          state_nxt      = STOP;
        end else begin
          clk_count_nxt = clk_count + 16'd1;
        end
      end
`endif
      STOP: begin
        if (clk_count == BIT_LAST) begin
          clk_count_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
            if (par_ok) begin
              data_nxt     = shift;
              data_rdy_nxt = 1'b1;
            end
          end else begin
            // Hold off until the line recovers so a break is not read as 0x00s.
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_HIGH;
          end
        end else begin
          clk_count_nxt = clk_count + 16'd1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift     <= '0;
      data      <= '0;
      data_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_count <= clk_count_nxt;
      bit_index <= bit_index_nxt;
      shift     <= shift_nxt;
      data      <= data_nxt;
      data_rdy  <= data_rdy_nxt;
      frame_err <= frame_err_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      parity_err <= parity_err_nxt;
    end
  end
`endif

  assign busy = (state != IDLE);

endmodule
